// File: rtl/jtag_host_shifter.sv
// JTAG host engine: turns SHIFT/TLR/TRST commands into TCK/TMS/TDI waveforms and captures TDO.
// Optional feature macro JTAG_HOST_TRST_EN adds the trst_no pin and the TRST command.
module jtag_host_shifter #(
  parameter int CLK_DIV = 4,
  parameter int MAX_LEN = 64
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [1:0]         cmd_op_i,
  input  logic [6:0]         cmd_len_i,
  input  logic [MAX_LEN-1:0] cmd_tms_i,
  input  logic [MAX_LEN-1:0] cmd_tdi_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [MAX_LEN-1:0] rsp_tdo_o,
  output logic               busy_o,
  output logic               tck_o,
  output logic               tms_o,
  output logic               td_o,
  input  logic               td_i
`ifdef JTAG_HOST_TRST_EN
  ,
  output logic               trst_no
`endif
);

  localparam int IW = $clog2(MAX_LEN) + 1;
  localparam logic [7:0]    HALF_LAST = 8'(CLK_DIV - 1);
  localparam logic [IW-1:0] TLR_LEN   = IW'(5);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_RSP
`ifdef JTAG_HOST_TRST_EN
    , S_TRST
`endif
  } state_e;

  state_e state_q, state_d;

  logic               cmd_ready_q, cmd_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               busy_q, busy_d;
  logic               tck_q, tck_d;
  logic               tms_q, tms_d;
  logic               td_q, td_d;
  logic               cap_q, cap_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [IW-1:0]      len_q, len_d;
  logic [MAX_LEN-1:0] tms_sr_q, tms_sr_d;
  logic [MAX_LEN-1:0] tdi_sr_q, tdi_sr_d;
  logic [MAX_LEN-1:0] mask_q, mask_d;
  logic [MAX_LEN-1:0] tdo_q, tdo_d;
`ifdef JTAG_HOST_TRST_EN
  logic               trst_q, trst_d;
`endif

  logic          accept;
  logic          half_done;
  logic          last_bit;
  logic [IW-1:0] len_clamp;

  assign accept    = cmd_valid_i && cmd_ready_q && (state_q == S_IDLE);
  assign half_done = (cnt_q == HALF_LAST);
  assign last_bit  = (idx_q == len_q - 1'b1);

  always_comb begin
    len_clamp = IW'(cmd_len_i);
    if (int'(cmd_len_i) > MAX_LEN) len_clamp = IW'(MAX_LEN);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (cmd_op_i == 2'b00 && len_clamp == '0) state_d = S_RSP;
`ifdef JTAG_HOST_TRST_EN
          else if (cmd_op_i == 2'b10)              state_d = S_TRST;
`endif
          else                                      state_d = S_LOW;
        end
      end
      S_LOW:  if (half_done) state_d = S_HIGH;
      S_HIGH: if (half_done) state_d = last_bit ? S_RSP : S_LOW;
      S_RSP:  if (rsp_ready_i) state_d = S_IDLE;
`ifdef JTAG_HOST_TRST_EN
      S_TRST: if (half_done && idx_q == IW'(3)) state_d = S_RSP;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // TLR reuses the shift engine with five TMS=1 bits and capture disabled
  always_comb begin
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    busy_d      = busy_q;
    tck_d       = tck_q;
    tms_d       = tms_q;
    td_d        = td_q;
    cap_d       = cap_q;
    cnt_d       = 8'd0;
    idx_d       = idx_q;
    len_d       = len_q;
    tms_sr_d    = tms_sr_q;
    tdi_sr_d    = tdi_sr_q;
    mask_d      = mask_q;
    tdo_d       = tdo_q;
`ifdef JTAG_HOST_TRST_EN
    trst_d      = (state_d != S_TRST);
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
          idx_d       = '0;
          mask_d      = {{(MAX_LEN-1){1'b0}}, 1'b1};
          tdo_d       = '0;
          if (cmd_op_i == 2'b00) begin
            len_d    = len_clamp;
            cap_d    = 1'b1;
            tms_sr_d = cmd_tms_i >> 1;
            tdi_sr_d = cmd_tdi_i >> 1;
            if (len_clamp == '0) begin
              rsp_valid_d = 1'b1;
            end else begin
              tms_d = cmd_tms_i[0];
              td_d  = cmd_tdi_i[0];
            end
          end
`ifdef JTAG_HOST_TRST_EN
          else if (cmd_op_i == 2'b10) begin
            cap_d = 1'b0;
          end
`endif
          else begin
            len_d    = TLR_LEN;
            cap_d    = 1'b0;
            tms_sr_d = '1;
            tdi_sr_d = '0;
            tms_d    = 1'b1;
            td_d     = 1'b0;
          end
        end
      end
      S_LOW: begin
        cnt_d = half_done ? 8'd0 : cnt_q + 8'd1;
        if (half_done) begin
          tck_d = 1'b1;
          if (cap_q && td_i) tdo_d = tdo_q | mask_q;
        end
      end
      S_HIGH: begin
        cnt_d = half_done ? 8'd0 : cnt_q + 8'd1;
        if (half_done) begin
          tck_d = 1'b0;
          if (last_bit) begin
            rsp_valid_d = 1'b1;
          end else begin
            idx_d    = idx_q + 1'b1;
            mask_d   = mask_q << 1;
            tms_d    = tms_sr_q[0];
            td_d     = tdi_sr_q[0];
            tms_sr_d = tms_sr_q >> 1;
            tdi_sr_d = tdi_sr_q >> 1;
          end
        end
      end
      S_RSP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          busy_d      = 1'b0;
        end
      end
`ifdef JTAG_HOST_TRST_EN
      S_TRST: begin
        cnt_d = half_done ? 8'd0 : cnt_q + 8'd1;
        if (half_done) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == IW'(3)) rsp_valid_d = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      tck_q       <= 1'b0;
      tms_q       <= 1'b1;
      td_q        <= 1'b0;
      cap_q       <= 1'b0;
      cnt_q       <= 8'd0;
      idx_q       <= '0;
      len_q       <= '0;
      tms_sr_q    <= '0;
      tdi_sr_q    <= '0;
      mask_q      <= '0;
      tdo_q       <= '0;
    end else begin
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
      tck_q       <= tck_d;
      tms_q       <= tms_d;
      td_q        <= td_d;
      cap_q       <= cap_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      tms_sr_q    <= tms_sr_d;
      tdi_sr_q    <= tdi_sr_d;
      mask_q      <= mask_d;
      tdo_q       <= tdo_d;
    end
  end

`ifdef JTAG_HOST_TRST_EN
  // TRST is held asserted through reset and releases on the first clock afterwards
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) trst_q <= 1'b0;
    else         trst_q <= trst_d;
  end
  assign trst_no = trst_q;
`endif

  assign cmd_ready_o = cmd_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_tdo_o   = tdo_q;
  assign busy_o      = busy_q;
  assign tck_o       = tck_q;
  assign tms_o       = tms_q;
  assign td_o        = td_q;

endmodule

// File: tb/tb_jtag_host_shifter.sv
// Testbench for jtag_host_shifter: randomized commands checked against a bit-level JTAG
// reference model through a response scoreboard, a TCK-edge checker and a TAP state tracker.
module tb_jtag_host_shifter;

  localparam int CLK_DIV = 2;
  localparam int MAX_LEN = 64;

  localparam int TAP_TLR = 0,  TAP_RTI = 1,  TAP_SELDR = 2,  TAP_CAPDR = 3;
  localparam int TAP_SHDR = 4, TAP_EX1DR = 5, TAP_PAUSEDR = 6, TAP_EX2DR = 7;
  localparam int TAP_UPDR = 8, TAP_SELIR = 9, TAP_CAPIR = 10, TAP_SHIR = 11;
  localparam int TAP_EX1IR = 12, TAP_PAUSEIR = 13, TAP_EX2IR = 14, TAP_UPIR = 15;

  logic               clk_i = 1'b0;
  logic               rst_ni = 1'b0;
  logic               cmd_valid_i = 1'b0;
  logic               cmd_ready_o;
  logic [1:0]         cmd_op_i = 2'b00;
  logic [6:0]         cmd_len_i = 7'd0;
  logic [MAX_LEN-1:0] cmd_tms_i = '0;
  logic [MAX_LEN-1:0] cmd_tdi_i = '0;
  logic               rsp_valid_o;
  logic               rsp_ready_i = 1'b0;
  logic [MAX_LEN-1:0] rsp_tdo_o;
  logic               busy_o;
  logic               tck_o;
  logic               tms_o;
  logic               td_o;
  logic               td_i;
`ifdef JTAG_HOST_TRST_EN
  logic               trst_no;
`endif

  logic invert   = 1'b0;
  logic hold_rsp = 1'b0;

  typedef struct {
    logic [MAX_LEN-1:0] tdo;
    int                 lat;
    int                 edges;
    int                 trst_lo;
  } exp_t;

  exp_t       exp_q[$];
  logic [1:0] edge_q[$];

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int acc_cyc      = 0;
  int edge_cnt     = 0;
  int trst_cnt     = 0;
  int lat_seen     = 0;
  int tap_state    = TAP_TLR;
  logic               tck_prev = 1'b0;
  logic               rsp_seen = 1'b0;
  logic [MAX_LEN-1:0] first_tdo = '0;

  // the target loops TDI back to TDO, optionally inverted per command
  assign td_i = td_o ^ invert;

  jtag_host_shifter #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_op_i    (cmd_op_i),
    .cmd_len_i   (cmd_len_i),
    .cmd_tms_i   (cmd_tms_i),
    .cmd_tdi_i   (cmd_tdi_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_tdo_o   (rsp_tdo_o),
    .busy_o      (busy_o),
    .tck_o       (tck_o),
    .tms_o       (tms_o),
    .td_o        (td_o),
    .td_i        (td_i)
`ifdef JTAG_HOST_TRST_EN
    ,
    .trst_no     (trst_no)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    tests_run++;
    tests_failed++;
    $display("[TB] FAIL %s: bound expired", name);
  endtask

  function automatic int tapNext(input int s, input logic tms);
    case (s)
      TAP_TLR:     return tms ? TAP_TLR   : TAP_RTI;
      TAP_RTI:     return tms ? TAP_SELDR : TAP_RTI;
      TAP_SELDR:   return tms ? TAP_SELIR : TAP_CAPDR;
      TAP_CAPDR:   return tms ? TAP_EX1DR : TAP_SHDR;
      TAP_SHDR:    return tms ? TAP_EX1DR : TAP_SHDR;
      TAP_EX1DR:   return tms ? TAP_UPDR  : TAP_PAUSEDR;
      TAP_PAUSEDR: return tms ? TAP_EX2DR : TAP_PAUSEDR;
      TAP_EX2DR:   return tms ? TAP_UPDR  : TAP_SHDR;
      TAP_UPDR:    return tms ? TAP_SELDR : TAP_RTI;
      TAP_SELIR:   return tms ? TAP_TLR   : TAP_CAPIR;
      TAP_CAPIR:   return tms ? TAP_EX1IR : TAP_SHIR;
      TAP_SHIR:    return tms ? TAP_EX1IR : TAP_SHIR;
      TAP_EX1IR:   return tms ? TAP_UPIR  : TAP_PAUSEIR;
      TAP_PAUSEIR: return tms ? TAP_EX2IR : TAP_PAUSEIR;
      TAP_EX2IR:   return tms ? TAP_UPIR  : TAP_SHIR;
      default:     return tms ? TAP_SELDR : TAP_RTI;
    endcase
  endfunction

  // Reference model: expected TCK edges, latency and captured data per command
  task automatic applyStimulus(input logic [1:0] op, input int len, input logic [63:0] tms,
                               input logic [63:0] tdi, input logic inv);
    exp_t e;
    int   lenc;
    int   n;
    bit   is_trst;
    lenc    = (len > MAX_LEN) ? MAX_LEN : len;
    is_trst = 1'b0;
`ifdef JTAG_HOST_TRST_EN
    is_trst = (op == 2'b10);
`endif
    e.tdo     = '0;
    e.trst_lo = 0;
    if (op == 2'b00) begin
      for (int i = 0; i < lenc; i++) e.tdo[i] = tdi[i] ^ inv;
      e.edges = lenc;
      e.lat   = 1 + lenc * 2 * CLK_DIV;
    end else if (is_trst) begin
      e.edges   = 0;
      e.lat     = 1 + 4 * CLK_DIV;
      e.trst_lo = 4 * CLK_DIV;
    end else begin
      e.edges = 5;
      e.lat   = 1 + 5 * 2 * CLK_DIV;
    end
    n = 0;
    @(negedge clk_i);
    while (!cmd_ready_o && n < 5000) begin
      @(negedge clk_i);
      n++;
    end
    if (!cmd_ready_o) failNow("ready_timeout");
    @(posedge clk_i);
    #1;
    invert      = inv;
    cmd_valid_i = 1'b1;
    cmd_op_i    = op;
    cmd_len_i   = 7'(len);
    cmd_tms_i   = tms;
    cmd_tdi_i   = tdi;
    @(negedge clk_i);
    checkOutput("accept_ready", 64'(cmd_ready_o), 64'd1);
    exp_q.push_back(e);
    if (op == 2'b00) begin
      for (int i = 0; i < lenc; i++) edge_q.push_back({tms[i], tdi[i]});
    end else if (!is_trst) begin
      for (int i = 0; i < 5; i++) edge_q.push_back(2'b10);
    end
    @(posedge clk_i);
    #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !cmd_ready_o) && n < 5000) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 5000) failNow("idle_timeout");
  endtask

  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      rsp_ready_i = hold_rsp ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: TCK edge checker, TAP tracker and response scoreboard
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      tck_prev = 1'b0;
      rsp_seen = 1'b0;
    end else begin
      cyc++;
      if (cmd_valid_i && cmd_ready_o) begin
        acc_cyc  = cyc;
        edge_cnt = 0;
        trst_cnt = 0;
      end
`ifdef JTAG_HOST_TRST_EN
      if (!trst_no) trst_cnt++;
`endif
      if (tck_o && !tck_prev) begin
        edge_cnt++;
        tap_state = tapNext(tap_state, tms_o);
        if (edge_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL tck_unexpected: got a rising edge, expected none");
        end else begin
          logic [1:0] be;
          be = edge_q.pop_front();
          checkOutput("edge_tms", 64'(tms_o), 64'(be[1]));
          checkOutput("edge_tdi", 64'(td_o), 64'(be[0]));
        end
      end
      tck_prev = tck_o;
      if (rsp_valid_o) begin
        if (!rsp_seen) begin
          rsp_seen  = 1'b1;
          first_tdo = rsp_tdo_o;
          lat_seen  = cyc - acc_cyc;
        end else begin
          checkOutput("hold_tdo", rsp_tdo_o, first_tdo);
          checkOutput("hold_cmd_ready", 64'(cmd_ready_o), 64'd0);
        end
        if (rsp_ready_i) begin
          rsp_seen = 1'b0;
          if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL rsp_unexpected: got tdo %h, expected no response", rsp_tdo_o);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            checkOutput("rsp_tdo", rsp_tdo_o, e.tdo);
            checkOutput("rsp_latency", 64'(lat_seen), 64'(e.lat));
            checkOutput("rsp_edges", 64'(edge_cnt), 64'(e.edges));
            checkOutput("rsp_busy", 64'(busy_o), 64'd1);
`ifdef JTAG_HOST_TRST_EN
            checkOutput("rsp_trst_low", 64'(trst_cnt), 64'(e.trst_lo));
`endif
          end
        end
      end
    end
  end

  initial begin
    int n;
    // reset values
    repeat (3) @(negedge clk_i);
    checkOutput("rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
    checkOutput("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    checkOutput("rst_tdo", rsp_tdo_o, 64'd0);
    checkOutput("rst_busy", 64'(busy_o), 64'd0);
    checkOutput("rst_tck", 64'(tck_o), 64'd0);
    checkOutput("rst_tms", 64'(tms_o), 64'd1);
    checkOutput("rst_td", 64'(td_o), 64'd0);
`ifdef JTAG_HOST_TRST_EN
    checkOutput("rst_trst", 64'(trst_no), 64'd0);
`endif
    #1;
    rst_ni = 1'b1;
    #1;
`ifdef JTAG_HOST_TRST_EN
    checkOutput("trst_before_edge", 64'(trst_no), 64'd0);
`endif
    @(negedge clk_i);
`ifdef JTAG_HOST_TRST_EN
    checkOutput("trst_after_edge", 64'(trst_no), 64'd1);
`endif
    checkOutput("post_rst_cmd_ready", 64'(cmd_ready_o), 64'd1);

    $display("[TB] shift len 8 loopback");
    applyStimulus(2'b00, 8, 64'h80, 64'hA5, 1'b0);
    waitIdle();

    $display("[TB] TLR then RTI step");
    applyStimulus(2'b01, 0, '0, '0, 1'b0);
    applyStimulus(2'b00, 1, 64'h0, 64'h1, 1'b0);
    waitIdle();
    checkOutput("tap_rti", 64'(tap_state), 64'(TAP_RTI));

    $display("[TB] length boundaries");
    applyStimulus(2'b00, 0, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
    applyStimulus(2'b00, 100, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
    applyStimulus(2'b00, 64, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
    waitIdle();

    $display("[TB] response backpressure");
    @(negedge clk_i);
    hold_rsp = 1'b1;
    applyStimulus(2'b00, 10, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
    n = 0;
    while (!rsp_valid_o && n < 1000) begin
      @(negedge clk_i);
      n++;
    end
    if (!rsp_valid_o) failNow("rsp_wait_timeout");
    @(posedge clk_i);
    #1;
    cmd_valid_i = 1'b1;
    cmd_op_i    = 2'b00;
    cmd_len_i   = 7'd5;
    repeat (20) @(posedge clk_i);
    #1;
    cmd_valid_i = 1'b0;
    @(negedge clk_i);
    hold_rsp = 1'b0;
    waitIdle();

    $display("[TB] reset during shift");
    applyStimulus(2'b00, 16, 64'h0, {$urandom, $urandom}, 1'b0);
    n = 0;
    while (edge_cnt < 4 && n < 1000) begin
      @(negedge clk_i);
      n++;
    end
    if (edge_cnt < 4) failNow("edge_wait_timeout");
    #2;
    rst_ni = 1'b0;
    exp_q.delete();
    edge_q.delete();
    #1;
    checkOutput("abort_tck", 64'(tck_o), 64'd0);
    checkOutput("abort_tms", 64'(tms_o), 64'd1);
    checkOutput("abort_rsp_valid", 64'(rsp_valid_o), 64'd0);
    checkOutput("abort_busy", 64'(busy_o), 64'd0);
    checkOutput("abort_cmd_ready", 64'(cmd_ready_o), 64'd1);
    repeat (2) @(negedge clk_i);
    #2;
    rst_ni = 1'b1;
    repeat (40) @(negedge clk_i);
    applyStimulus(2'b00, 12, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
    waitIdle();

    $display("[TB] op 10 and reserved op");
    applyStimulus(2'b10, 0, '0, '0, 1'b0);
    applyStimulus(2'b11, 7, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
    waitIdle();

    $display("[TB] random commands");
    for (int k = 0; k < 40; k++) begin
      logic [1:0] op;
      op = ($urandom_range(0, 9) < 7) ? 2'b00 : 2'($urandom_range(1, 3));
      applyStimulus(op, $urandom_range(0, 100), {$urandom, $urandom}, {$urandom, $urandom},
                    1'($urandom_range(0, 1)));
    end
    waitIdle();
    repeat (5) @(negedge clk_i);
    checkOutput("end_tck", 64'(tck_o), 64'd0);
    checkOutput("end_busy", 64'(busy_o), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
